// File: rtl/cache_defs_pkg.sv
// Shared definitions for the victim buffer beside the write-back dcache.
// Holds the geometry constants, the per-entry storage record and the
// encoding of how an insertion slot was chosen.
package cache_defs;

    localparam int VC_ENTRIES     = 4;
    localparam int VC_IDX_BITS    = $clog2(VC_ENTRIES);
    localparam int LINE_ADDR_BITS = 28;
    localparam int LINE_WIDTH     = 128;
    localparam int WORD_WIDTH     = 32;
    localparam int OFFSET_BITS    = $clog2(LINE_WIDTH / WORD_WIDTH);

    typedef struct packed {
        logic                      valid;
        logic [LINE_ADDR_BITS-1:0] addr;
        logic [LINE_WIDTH-1:0]     line;
    } type_vc_entry_s;

    typedef enum logic [1:0] {
        VC_SEL_SWAP,
        VC_SEL_DUP,
        VC_SEL_FREE,
        VC_SEL_FIFO
    } type_vc_slot_sel_e;

endpackage

// File: rtl/victim_cache_repl_sel.sv
// vc_repl_sel: picks the slot an incoming eviction line is written to and
// owns the round-robin replacement pointer.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   valid         valid bit per entry
//   swap          extraction of the hit entry in the same cycle as insert
//   swap_idx      index of the hit entry
//   dup           an entry already holds the inserted address
//   dup_idx       index of that entry
//   insert        insertion actually taking effect this cycle
//   flush         clear all entries (resets the pointer)
//   slot_idx      chosen slot
//   slot_sel      why that slot was chosen
module vc_repl_sel
    import cache_defs::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [VC_ENTRIES-1:0]  valid,
    input  logic                   swap,
    input  logic [VC_IDX_BITS-1:0] swap_idx,
    input  logic                   dup,
    input  logic [VC_IDX_BITS-1:0] dup_idx,
    input  logic                   insert,
    input  logic                   flush,
    output logic [VC_IDX_BITS-1:0] slot_idx,
    output type_vc_slot_sel_e      slot_sel
);

    logic [VC_IDX_BITS-1:0] fifo_ptr;
    logic [VC_IDX_BITS-1:0] free_idx;
    logic                   free_found;

    // Scan from the top down so the last assignment is the lowest free index.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = VC_IDX_BITS'(i);
            end
        end
    end

    always_comb begin
        slot_sel = VC_SEL_FIFO;
        slot_idx = fifo_ptr;
        if (swap) begin
            slot_sel = VC_SEL_SWAP;
            slot_idx = swap_idx;
        end else if (dup) begin
            slot_sel = VC_SEL_DUP;
            slot_idx = dup_idx;
        end else if (free_found) begin
            slot_sel = VC_SEL_FREE;
            slot_idx = free_idx;
        end
    end

    // Power-of-two entry count: natural wrap gives the modulo.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_ptr <= '0;
        end else if (flush) begin
            fifo_ptr <= '0;
        end else if (insert && (slot_sel == VC_SEL_FIFO)) begin
            fifo_ptr <= fifo_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/victim_cache.sv
// victim_cache: small fully-associative buffer of clean lines evicted from
// the dcache. A lookup address/offset is captured on lookup_req_i and then
// compared combinationally against the live entries, so the hit outputs
// follow inserts and invalidates made while the request is outstanding.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   lookup_req_i          capture lookup_addr_i / lookup_offset_i
//   lookup_addr_i         request line address
//   lookup_offset_i       word offset within the line
//   victim_hit_o          held address matches a valid entry
//   hit_line_o            matching line (0 on miss)
//   hit_word_o            word at held offset of hit_line_o (0 on miss)
//   write_to_victim_i     insert evict_addr_i / evict_line_i
//   evict_addr_i          inserted line address
//   evict_line_i          inserted line data
//   write_from_victim_i   invalidate the currently hit entry
//   flush_i               invalidate everything (wins over insert/extract)
//   vc_full_o             all entries valid
module victim_cache
    import cache_defs::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      lookup_req_i,
    input  logic [LINE_ADDR_BITS-1:0] lookup_addr_i,
    input  logic [OFFSET_BITS-1:0]    lookup_offset_i,
    output logic                      victim_hit_o,
    output logic [LINE_WIDTH-1:0]     hit_line_o,
    output logic [WORD_WIDTH-1:0]     hit_word_o,
    input  logic                      write_to_victim_i,
    input  logic [LINE_ADDR_BITS-1:0] evict_addr_i,
    input  logic [LINE_WIDTH-1:0]     evict_line_i,
    input  logic                      write_from_victim_i,
    input  logic                      flush_i,
    output logic                      vc_full_o
);

    type_vc_entry_s          entry_q [VC_ENTRIES];
    logic [LINE_ADDR_BITS-1:0] held_addr;
    logic [OFFSET_BITS-1:0]  held_offset;

    logic [VC_ENTRIES-1:0]   valid_vec;
    logic [VC_ENTRIES-1:0]   hit_vec;
    logic [VC_ENTRIES-1:0]   dup_vec;
    logic [VC_IDX_BITS-1:0]  hit_idx;
    logic [VC_IDX_BITS-1:0]  dup_idx;
    logic                    dup_found;
    logic                    extract;
    logic                    insert;
    logic [VC_IDX_BITS-1:0]  slot_idx;
    type_vc_slot_sel_e       slot_sel;

    always_comb begin
        valid_vec = '0;
        hit_vec   = '0;
        dup_vec   = '0;
        for (int i = 0; i < VC_ENTRIES; i++) begin
            valid_vec[i] = entry_q[i].valid;
            hit_vec[i]   = entry_q[i].valid && (entry_q[i].addr == held_addr);
            dup_vec[i]   = entry_q[i].valid && (entry_q[i].addr == evict_addr_i);
        end
    end

    // Duplicates are never created, so at most one bit of each vector is set.
    always_comb begin
        hit_idx    = '0;
        dup_idx    = '0;
        hit_line_o = '0;
        for (int i = 0; i < VC_ENTRIES; i++) begin
            if (hit_vec[i]) begin
                hit_idx    = VC_IDX_BITS'(i);
                hit_line_o = entry_q[i].line;
            end
            if (dup_vec[i]) begin
                dup_idx = VC_IDX_BITS'(i);
            end
        end
    end

    assign victim_hit_o = |hit_vec;
    assign dup_found    = |dup_vec;
    assign hit_word_o   = hit_line_o[WORD_WIDTH*int'(held_offset) +: WORD_WIDTH];
    assign vc_full_o    = &valid_vec;

    assign extract = write_from_victim_i && victim_hit_o;
    assign insert  = write_to_victim_i && !flush_i;

    vc_repl_sel u_repl_sel (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (valid_vec),
        .swap     (extract),
        .swap_idx (hit_idx),
        .dup      (dup_found),
        .dup_idx  (dup_idx),
        .insert   (insert),
        .flush    (flush_i),
        .slot_idx (slot_idx),
        .slot_sel (slot_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_addr   <= '0;
            held_offset <= '0;
        end else if (lookup_req_i) begin
            held_addr   <= lookup_addr_i;
            held_offset <= lookup_offset_i;
        end
    end

    // On a swap the insert targets the hit slot; its write comes after the
    // invalidate so the refilled entry stays valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VC_ENTRIES; i++) begin
                entry_q[i] <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < VC_ENTRIES; i++) begin
                entry_q[i].valid <= 1'b0;
            end
        end else begin
            if (extract) begin
                entry_q[hit_idx].valid <= 1'b0;
            end
            if (insert) begin
                entry_q[slot_idx].valid <= 1'b1;
                entry_q[slot_idx].addr  <= evict_addr_i;
                entry_q[slot_idx].line  <= evict_line_i;
            end
        end
    end

endmodule

// File: tb/tb_victim_cache.sv
module tb_victim_cache;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         lookup_req = 1'b0;
    logic [27:0]  lookup_addr = '0;
    logic [1:0]   lookup_offset = '0;
    logic         victim_hit;
    logic [127:0] hit_line;
    logic [31:0]  hit_word;
    logic         write_to = 1'b0;
    logic [27:0]  evict_addr = '0;
    logic [127:0] evict_line = '0;
    logic         write_from = 1'b0;
    logic         flush = 1'b0;
    logic         vc_full;

    typedef struct {
        string        name;
        logic         hit;
        logic [127:0] line;
        logic [31:0]  word;
        logic         full;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    event chk_ev;

    always #5 clk = ~clk;

    victim_cache dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .lookup_req_i        (lookup_req),
        .lookup_addr_i       (lookup_addr),
        .lookup_offset_i     (lookup_offset),
        .victim_hit_o        (victim_hit),
        .hit_line_o          (hit_line),
        .hit_word_o          (hit_word),
        .write_to_victim_i   (write_to),
        .evict_addr_i        (evict_addr),
        .evict_line_i        (evict_line),
        .write_from_victim_i (write_from),
        .flush_i             (flush),
        .vc_full_o           (vc_full)
    );

    function automatic logic [127:0] mkl(input logic [15:0] t);
        return {t, 16'h0003, t, 16'h0002, t, 16'h0001, t, 16'h0000};
    endfunction

    // Monitor: each time the stimulus marks the outputs as presented, pop
    // the queued expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_empty: output presented with no expectation queued");
            end
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_tests++;
                if (victim_hit !== e.hit) begin
                    n_fail++;
                    $display("FAIL %s hit: got %0b want %0b", e.name, victim_hit, e.hit);
                end
                n_tests++;
                if (hit_line !== e.line) begin
                    n_fail++;
                    $display("FAIL %s line: got %h want %h", e.name, hit_line, e.line);
                end
                n_tests++;
                if (hit_word !== e.word) begin
                    n_fail++;
                    $display("FAIL %s word: got %h want %h", e.name, hit_word, e.word);
                end
                n_tests++;
                if (vc_full !== e.full) begin
                    n_fail++;
                    $display("FAIL %s full: got %0b want %0b", e.name, vc_full, e.full);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [27:0] a, input logic [1:0] off);
        lookup_req    = 1'b1;
        lookup_addr   = a;
        lookup_offset = off;
        tick();
        lookup_req    = 1'b0;
    endtask

    task automatic insert(input logic [27:0] a, input logic [127:0] l);
        write_to   = 1'b1;
        evict_addr = a;
        evict_line = l;
        tick();
        write_to   = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic h, input logic [127:0] l,
                              input logic [31:0] w, input logic f);
        exp_t e;
        e.name = nm;
        e.hit  = h;
        e.line = l;
        e.word = w;
        e.full = f;
        sb_q.push_back(e);
        @(negedge clk);
        -> chk_ev;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        expect_out("rst", 1'b0, '0, '0, 1'b0);
        lookup(28'h0000123, 2'd0);
        expect_out("miss_empty", 1'b0, '0, '0, 1'b0);

        insert(28'h0000123, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        lookup(28'h0000123, 2'd2);
        expect_out("hit_w2", 1'b1, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 32'hCCCCCCCC, 1'b0);

        lookup(28'h0000456, 2'd3);
        expect_out("miss_456", 1'b0, '0, '0, 1'b0);
        insert(28'h0000456, mkl(16'h4560));
        expect_out("track_ins", 1'b1, mkl(16'h4560), 32'h45600003, 1'b0);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_out("flush_clr", 1'b0, '0, '0, 1'b0);

        // Fill A0..A3, then A4 overwrites A0 via the pointer.
        for (int k = 0; k < 3; k++) insert(28'h0001000 + 28'(k), mkl(16'hA000 + 16'(k)));
        lookup(28'h0001002, 2'd0);
        expect_out("a2_not_full", 1'b1, mkl(16'hA002), 32'hA0020000, 1'b0);
        insert(28'h0001003, mkl(16'hA003));
        expect_out("full_a3", 1'b1, mkl(16'hA002), 32'hA0020000, 1'b1);
        insert(28'h0001004, mkl(16'hA004));
        lookup(28'h0001000, 2'd0);
        expect_out("a0_gone", 1'b0, '0, '0, 1'b1);
        lookup(28'h0001001, 2'd1);
        expect_out("a1_hit", 1'b1, mkl(16'hA001), 32'hA0010001, 1'b1);

        // Swap: A1 slot refilled with B in the same cycle.
        write_from = 1'b1;
        write_to   = 1'b1;
        evict_addr = 28'h0002000;
        evict_line = mkl(16'hB000);
        tick();
        write_from = 1'b0;
        write_to   = 1'b0;
        expect_out("swap_a1_miss", 1'b0, '0, '0, 1'b1);
        lookup(28'h0002000, 2'd3);
        expect_out("b_hit", 1'b1, mkl(16'hB000), 32'hB0000003, 1'b1);

        // Pointer still 1 after the swap, so C lands on B's slot.
        insert(28'h0003000, mkl(16'hC000));
        lookup(28'h0002000, 2'd0);
        expect_out("b_repl", 1'b0, '0, '0, 1'b1);
        lookup(28'h0001002, 2'd0);
        expect_out("a2_kept", 1'b1, mkl(16'hA002), 32'hA0020000, 1'b1);

        // Duplicate overwrite of A3, pointer stays 2.
        insert(28'h0001003, mkl(16'hE003));
        lookup(28'h0001003, 2'd1);
        expect_out("dup_new", 1'b1, mkl(16'hE003), 32'hE0030001, 1'b1);
        insert(28'h0004000, mkl(16'hD000));
        lookup(28'h0001002, 2'd0);
        expect_out("a2_fifo", 1'b0, '0, '0, 1'b1);
        lookup(28'h0001003, 2'd0);
        expect_out("a3_kept", 1'b1, mkl(16'hE003), 32'hE0030000, 1'b1);

        // Plain extraction, then refill into the freed slot (pointer at 3).
        lookup(28'h0001004, 2'd2);
        expect_out("a4_hit", 1'b1, mkl(16'hA004), 32'hA0040002, 1'b1);
        write_from = 1'b1;
        tick();
        write_from = 1'b0;
        expect_out("extract", 1'b0, '0, '0, 1'b0);
        insert(28'h0005000, mkl(16'h5000));
        lookup(28'h0005000, 2'd0);
        expect_out("free_slot", 1'b1, mkl(16'h5000), 32'h50000000, 1'b1);
        insert(28'h0006000, mkl(16'h6000));
        lookup(28'h0001003, 2'd0);
        expect_out("ptr_kept", 1'b0, '0, '0, 1'b1);

        // Extraction request without a hit is ignored.
        lookup(28'h0007777, 2'd0);
        expect_out("miss_x", 1'b0, '0, '0, 1'b1);
        write_from = 1'b1;
        tick();
        write_from = 1'b0;
        lookup(28'h0003000, 2'd0);
        expect_out("ign_wfv", 1'b1, mkl(16'hC000), 32'hC0000000, 1'b1);

        // Advance pointer to 1, then flush together with an insert.
        insert(28'h0007000, mkl(16'h7000));
        flush      = 1'b1;
        write_to   = 1'b1;
        evict_addr = 28'h0008000;
        evict_line = mkl(16'h8000);
        tick();
        flush      = 1'b0;
        write_to   = 1'b0;
        lookup(28'h0008000, 2'd0);
        expect_out("flush_drop", 1'b0, '0, '0, 1'b0);
        lookup(28'h0003000, 2'd0);
        expect_out("flush_c", 1'b0, '0, '0, 1'b0);

        // Pointer must be back at 0: P4 replaces P0, not P1.
        for (int k = 0; k < 5; k++) insert(28'h0009000 + 28'(k), mkl(16'h9000 + 16'(k)));
        lookup(28'h0009000, 2'd0);
        expect_out("ptr_rst_p0", 1'b0, '0, '0, 1'b1);
        lookup(28'h0009001, 2'd0);
        expect_out("ptr_rst_p1", 1'b1, mkl(16'h9001), 32'h90010000, 1'b1);

        // Asynchronous reset in the middle of an insert.
        write_to   = 1'b1;
        evict_addr = 28'h000A000;
        evict_line = mkl(16'hA0A0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        expect_out("async_rst", 1'b0, '0, '0, 1'b0);
        write_to = 1'b0;
        rst_n    = 1'b1;
        tick();
        lookup(28'h0009001, 2'd0);
        expect_out("post_rst", 1'b0, '0, '0, 1'b0);

        tick();
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_left: %0d expectations never checked, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
